// File: rtl/lane_collector.sv
// Four-lane RX deskew and reassembly: per-lane FIFOs aligned on the common sync
// marker, with realignment on sync mismatch, FIFO overflow or sync timeout.
module lane_collector #(
  parameter int UNITWIDTH    = 66,
  parameter int FIFO_DEPTH   = 8,
  parameter int SYNC_TIMEOUT = 1100
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [UNITWIDTH-1:0]   in_rxdata0,
  input  logic [UNITWIDTH-1:0]   in_rxdata1,
  input  logic [UNITWIDTH-1:0]   in_rxdata2,
  input  logic [UNITWIDTH-1:0]   in_rxdata3,
  input  logic                   in_rxdata_en0,
  input  logic                   in_rxdata_en1,
  input  logic                   in_rxdata_en2,
  input  logic                   in_rxdata_en3,
  input  logic                   in_rxsync0,
  input  logic                   in_rxsync1,
  input  logic                   in_rxsync2,
  input  logic                   in_rxsync3,
  output logic [4*UNITWIDTH-1:0] out_rxdata,
  output logic                   out_rxdata_en,
  output logic                   out_aligned,
  output logic                   out_align_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SYNC_TIMEOUT);

  typedef enum logic {HUNT, ALIGNED} state_t;

  state_t                 state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic [4*UNITWIDTH-1:0] wr_data, head_data, rxdata_reg;
  logic [3:0]             wr_en, wr_sync, empty, full, head_sync, pop;
  logic                   flush, err_next, en_next, err_reg, en_reg;
  logic                   all_valid, all_sync, any_sync;

  assign wr_data = {in_rxdata3, in_rxdata2, in_rxdata1, in_rxdata0};
  assign wr_en   = {in_rxdata_en3, in_rxdata_en2, in_rxdata_en1, in_rxdata_en0};
  assign wr_sync = {in_rxsync3, in_rxsync2, in_rxsync1, in_rxsync0};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [UNITWIDTH:0] mem [FIFO_DEPTH];
      // Pointers carry one extra bit so full and empty are distinguishable.
      logic [AW:0]        wr_ptr_reg, rd_ptr_reg;

      always_ff @(posedge clk) begin
        if (reset || flush) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else begin
          if (wr_en[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop[gi])   rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (wr_en[gi])
          mem[wr_ptr_reg[AW-1:0]] <= {wr_sync[gi], wr_data[gi*UNITWIDTH +: UNITWIDTH]};
      end

      assign empty[gi]     = (wr_ptr_reg == rd_ptr_reg);
      assign full[gi]      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                             (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
      assign head_sync[gi] = mem[rd_ptr_reg[AW-1:0]][UNITWIDTH];
      assign head_data[gi*UNITWIDTH +: UNITWIDTH] = mem[rd_ptr_reg[AW-1:0]][UNITWIDTH-1:0];
    end
  endgenerate

  assign all_valid = &(~empty);
  assign all_sync  = &head_sync;
  assign any_sync  = |head_sync;

  always_comb begin
    pop        = '0;
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = 1'b0;
    en_next    = 1'b0;
    flush      = 1'b0;
    case (state_reg)
      HUNT: begin
        cnt_next = '0;
        pop      = ~empty & ~head_sync;
        if (all_valid && all_sync) begin
          pop        = 4'hF;
          state_next = ALIGNED;
        end
      end
      ALIGNED: begin
        cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
        if (all_valid && any_sync && !all_sync) begin
          err_next   = 1'b1;
          state_next = HUNT;
        end else if (all_valid && all_sync) begin
          pop      = 4'hF;
          cnt_next = '0;
        end else if (cnt_reg == CNT_MAX) begin
          err_next   = 1'b1;
          state_next = HUNT;
        end else if (all_valid) begin
          pop     = 4'hF;
          en_next = 1'b1;
        end
      end
      default: state_next = HUNT;
    endcase
    // A write into a full lane that is not draining this cycle loses data: start over.
    if (|(wr_en & full & ~pop)) begin
      flush      = 1'b1;
      pop        = '0;
      en_next    = 1'b0;
      err_next   = 1'b1;
      cnt_next   = '0;
      state_next = HUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= HUNT;
      cnt_reg    <= '0;
      rxdata_reg <= '0;
      en_reg     <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      en_reg    <= en_next;
      err_reg   <= err_next;
      if (en_next) rxdata_reg <= head_data;
    end
  end

  assign out_rxdata    = rxdata_reg;
  assign out_rxdata_en = en_reg;
  assign out_aligned   = (state_reg == ALIGNED);
  assign out_align_err = err_reg;
endmodule

// File: tb/tb_lane_collector.sv
// Directed bench for lane_collector: per-cycle vector tables for deskew, mismatch
// and overflow, plus hand-written timeout, keep-alive and mid-stream reset sequences.
module tb_lane_collector;
  localparam int UW = 66;

  typedef struct packed {
    logic [3:0]      en;
    logic [3:0]      sync;
    logic [3:0][7:0] val;
    logic            exp_en;
    logic            exp_aligned;
    logic            exp_err;
    logic [7:0]      exp_i;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [UW-1:0]   din [4];
  logic [3:0]      en_b = '0;
  logic [3:0]      sync_b = '0;
  logic [4*UW-1:0] out_rxdata;
  logic            out_rxdata_en, out_aligned, out_align_err;

  vec_t vecs [20];
  int   n_cmp = 0;
  int   n_miss = 0;

  lane_collector dut (
    .clk(clk), .reset(reset),
    .in_rxdata0(din[0]), .in_rxdata1(din[1]), .in_rxdata2(din[2]), .in_rxdata3(din[3]),
    .in_rxdata_en0(en_b[0]), .in_rxdata_en1(en_b[1]),
    .in_rxdata_en2(en_b[2]), .in_rxdata_en3(en_b[3]),
    .in_rxsync0(sync_b[0]), .in_rxsync1(sync_b[1]),
    .in_rxsync2(sync_b[2]), .in_rxsync3(sync_b[3]),
    .out_rxdata(out_rxdata), .out_rxdata_en(out_rxdata_en),
    .out_aligned(out_aligned), .out_align_err(out_align_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [4*UW-1:0] make_word(input int i);
    logic [4*UW-1:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) w[k*UW +: UW] = UW'(k*16 + i);
    return w;
  endfunction

  task automatic chk(input string name, input logic [4*UW-1:0] act, input logic [4*UW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic set_inputs(input logic [3:0] en, input logic [3:0] sync, input logic [3:0][7:0] val);
    for (int k = 0; k < 4; k++) din[k] = UW'(val[k]);
    en_b   = en;
    sync_b = sync;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    set_inputs('0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_vecs(input int n, input string tname);
    logic [4*UW-1:0] exp_word;
    exp_word = '0;
    for (int c = 0; c < n; c++) begin
      set_inputs(vecs[c].en, vecs[c].sync, vecs[c].val);
      @(negedge clk);
      if (vecs[c].exp_en) exp_word = make_word(int'(vecs[c].exp_i));
      chk($sformatf("%s c%0d aligned", tname, c), out_aligned, vecs[c].exp_aligned);
      chk($sformatf("%s c%0d err", tname, c), out_align_err, vecs[c].exp_err);
      chk($sformatf("%s c%0d en", tname, c), out_rxdata_en, vecs[c].exp_en);
      chk($sformatf("%s c%0d data", tname, c), out_rxdata, exp_word);
      $display("%s c%0d en_in=%b sync_in=%b -> en=%b aligned=%b err=%b lane0=%0d",
               tname, c, vecs[c].en, vecs[c].sync, out_rxdata_en, out_aligned,
               out_align_err, out_rxdata[7:0]);
      step();
    end
    set_inputs('0, '0, '0);
  endtask

  // All lanes carry sync then units 1..8; lane k starts s[k] cycles late.
  task automatic fill_skew(input int s0, input int s1, input int s2, input int s3, input int n);
    int s [4];
    int smax;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    smax = 0;
    for (int k = 0; k < 4; k++) if (s[k] > smax) smax = s[k];
    for (int c = 0; c < n; c++) begin
      vecs[c] = '0;
      for (int k = 0; k < 4; k++) begin
        if (c >= s[k] && c <= s[k] + 8) begin
          vecs[c].en[k]  = 1'b1;
          vecs[c].sync[k] = (c == s[k]);
          vecs[c].val[k] = 8'(k*16 + c - s[k]);
        end
      end
      vecs[c].exp_aligned = (c >= smax + 2);
      vecs[c].exp_en      = (c >= smax + 3) && (c <= smax + 10);
      vecs[c].exp_i       = 8'(c - smax - 2);
    end
  endtask

  initial begin
    int acnt, drops, errs;
    logic seen_err, aligned_at_err;
    for (int k = 0; k < 4; k++) din[k] = '0;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("reset data", out_rxdata, '0);
    chk("reset en", out_rxdata_en, 1'b0);
    chk("reset aligned", out_aligned, 1'b0);
    chk("reset err", out_align_err, 1'b0);
    step();

    // Zero skew
    fill_skew(0, 0, 0, 0, 13);
    run_vecs(13, "noskew");

    // Lane0 +1, lane2 +3
    do_reset();
    fill_skew(1, 0, 3, 0, 16);
    run_vecs(16, "skew");

    // Lanes 2,3 slip by one garbage unit: sync only on lanes 0,1, then realign
    do_reset();
    for (int c = 0; c < 16; c++) begin
      vecs[c] = '0;
      for (int k = 0; k < 4; k++) begin
        if (k < 2) begin
          if (c == 0 || c == 5) begin
            vecs[c].en[k] = 1'b1; vecs[c].sync[k] = 1'b1; vecs[c].val[k] = 8'(k*16);
          end else if (c >= 1 && c <= 4) begin
            vecs[c].en[k] = 1'b1; vecs[c].val[k] = 8'(k*16 + c);
          end else if (c >= 6 && c <= 9) begin
            vecs[c].en[k] = 1'b1; vecs[c].val[k] = 8'(k*16 + c - 1);
          end
        end else begin
          if (c == 0 || c == 6) begin
            vecs[c].en[k] = 1'b1; vecs[c].sync[k] = 1'b1; vecs[c].val[k] = 8'(k*16);
          end else if (c >= 1 && c <= 4) begin
            vecs[c].en[k] = 1'b1; vecs[c].val[k] = 8'(k*16 + c);
          end else if (c == 5) begin
            vecs[c].en[k] = 1'b1; vecs[c].val[k] = 8'hEE;
          end else if (c >= 7 && c <= 10) begin
            vecs[c].en[k] = 1'b1; vecs[c].val[k] = 8'(k*16 + c - 2);
          end
        end
      end
      vecs[c].exp_aligned = (c >= 2 && c <= 6) || (c >= 9);
      vecs[c].exp_err     = (c == 7);
      if (c >= 3 && c <= 6) begin
        vecs[c].exp_en = 1'b1; vecs[c].exp_i = 8'(c - 2);
      end else if (c >= 10 && c <= 13) begin
        vecs[c].exp_en = 1'b1; vecs[c].exp_i = 8'(c - 5);
      end
    end
    run_vecs(16, "mismatch");

    // Lane3 skew 9: lanes 0..2 overflow at cycle 8, flush, then a fresh sync realigns
    do_reset();
    for (int c = 0; c < 17; c++) begin
      vecs[c] = '0;
      for (int k = 0; k < 3; k++) begin
        if (c == 0 || c == 12) begin
          vecs[c].en[k] = 1'b1; vecs[c].sync[k] = 1'b1; vecs[c].val[k] = 8'(k*16);
        end else if (c <= 11) begin
          vecs[c].en[k] = 1'b1; vecs[c].val[k] = 8'(k*16 + c);
        end
      end
      if (c == 9) begin
        vecs[c].en[3] = 1'b1; vecs[c].sync[3] = 1'b1; vecs[c].val[3] = 8'd48;
      end
      vecs[c].exp_err     = (c == 9);
      vecs[c].exp_aligned = (c >= 14);
    end
    run_vecs(17, "overflow");

    // Sync timeout: aligned from cnt=0 through cnt=1100, then one error pulse
    do_reset();
    set_inputs(4'hF, 4'hF, '0);
    step();
    set_inputs('0, '0, '0);
    acnt = 0; seen_err = 1'b0; aligned_at_err = 1'b1;
    for (int t = 0; t < 1300 && !seen_err; t++) begin
      @(negedge clk);
      if (out_align_err) begin
        seen_err = 1'b1;
        aligned_at_err = out_aligned;
      end else if (out_aligned) begin
        acnt++;
      end
      step();
    end
    chk("timeout err seen", seen_err, 1'b1);
    chk("timeout aligned cycles", acnt, 1101);
    chk("timeout aligned at err", aligned_at_err, 1'b0);
    @(negedge clk);
    chk("timeout err one pulse", out_align_err, 1'b0);
    chk("timeout hunt", out_aligned, 1'b0);
    $display("timeout: aligned for %0d cycles, err=%b", acnt, seen_err);
    step();

    // Sync every 1024 cycles keeps alignment
    do_reset();
    drops = 0; errs = 0;
    for (int t = 0; t < 3200; t++) begin
      if (t % 1024 == 0) set_inputs(4'hF, 4'hF, '0);
      else set_inputs('0, '0, '0);
      @(negedge clk);
      if (t >= 2 && !out_aligned) drops++;
      if (out_align_err) errs++;
      step();
    end
    set_inputs('0, '0, '0);
    chk("keepalive drops", drops, 0);
    chk("keepalive errs", errs, 0);
    $display("keepalive: drops=%0d errs=%0d", drops, errs);

    // Reset mid-frame
    do_reset();
    for (int t = 0; t < 6; t++) begin
      set_inputs(4'hF, (t == 0) ? 4'hF : 4'h0,
                 {8'(48 + t), 8'(32 + t), 8'(16 + t), 8'(t)});
      if (t == 5) reset = 1'b1;
      @(negedge clk);
      if (t == 5) begin
        chk("midreset pre en", out_rxdata_en, 1'b1);
        chk("midreset pre data", out_rxdata, make_word(3));
      end
      step();
    end
    reset = 1'b0;
    set_inputs('0, '0, '0);
    @(negedge clk);
    chk("midreset data", out_rxdata, '0);
    chk("midreset en", out_rxdata_en, 1'b0);
    chk("midreset aligned", out_aligned, 1'b0);
    chk("midreset err", out_align_err, 1'b0);
    $display("midreset: en=%b aligned=%b err=%b", out_rxdata_en, out_aligned, out_align_err);
    repeat (3) step();
    @(negedge clk);
    chk("midreset stays hunt", out_aligned, 1'b0);
    chk("midreset no output", out_rxdata_en, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end
endmodule
